// File: rtl/axi_rdata_merge4k_if.sv
// R-channel input and merged data-stream output of the 4K read-data merger.
// The slave modport is the merger's view; the master modport is the environment's view.
interface axi_rdata_merge4k_if #(
    parameter int AXI_IDW = 4,
    parameter int AXI_DW  = 128
);
    // AXI R channel from the fabric
    logic               i_rvalid;
    logic [AXI_IDW-1:0] i_rid;
    logic [AXI_DW-1:0]  i_rdata;
    logic [1:0]         i_rresp;
    logic               i_rlast;
    logic               o_rready;

    // Merged stream towards the DMA data path
    logic               o_dvalid;
    logic [AXI_DW-1:0]  o_ddata;
    logic [1:0]         o_dresp;
    logic               o_dlast;
    logic               i_dready;

    modport slave (
        input  i_rvalid, i_rid, i_rdata, i_rresp, i_rlast, i_dready,
        output o_rready, o_dvalid, o_ddata, o_dresp, o_dlast
    );

    modport master (
        output i_rvalid, i_rid, i_rdata, i_rresp, i_rlast, i_dready,
        input  o_rready, o_dvalid, o_ddata, o_dresp, o_dlast
    );
endinterface

// File: rtl/axi_rdata_merge4k.sv
// Merges the two R bursts of a 4K-split logical read burst back into one
// burst for the DMA data path. Data passes through combinationally; the
// command FIFO tells, per logical burst, whether to expect one or two RLASTs.
module axi_rdata_merge4k #(
    parameter int AXI_IDW   = 4,
    parameter int AXI_DW    = 128,
    parameter int CMD_DEPTH = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      cmd_push,
    input  logic                      cmd_cross4k,
    input  logic [3:0]                cmd_len,
    output logic                      cmd_full,
    output logic                      cmd_empty,
    axi_rdata_merge4k_if.slave        rif,
    output logic                      axi_burst_xdata_ok,
    output logic                      len_err,
    output logic                      cmd_ovf_err
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;

    typedef struct packed {
        logic       cross4k;
        logic [3:0] len;
    } cmd_t;

    typedef enum logic {
        SEG_FIRST  = 1'b0,
        SEG_SECOND = 1'b1
    } seg_e;

    // Numeric max of two AXI responses (DECERR > SLVERR > EXOKAY > OKAY).
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    cmd_t               mem_q [CMD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    seg_e               seg_q, seg_d;
    logic [4:0]         beat_cnt_q, beat_cnt_d;
    logic [1:0]         resp_acc_q, resp_acc_d;
    logic               len_err_q, len_err_d;
    logic               ovf_err_q, ovf_err_d;

    cmd_t               head;
    logic               hs;
    logic               is_final;
    logic               pop;
    logic               push_ok;
    logic [AXI_DW-1:0]  ddata_gated;
    logic [AXI_IDW-1:0] unused_rid;

    // In-order only: the R id carries no information for the merge.
    assign unused_rid = rif.i_rid;

    assign head      = mem_q[rd_ptr_q];
    assign cmd_empty = (count_q == '0);
    assign cmd_full  = (count_q == (PTR_W+1)'(CMD_DEPTH));

    // No command outstanding means nothing to attribute a beat to, so stall R.
    assign rif.o_rready = rif.i_dready & ~cmd_empty;
    assign rif.o_dvalid = rif.i_rvalid & ~cmd_empty;
    assign hs           = rif.i_rvalid & rif.o_rready;

    // A split burst carries two RLASTs; only the second-segment one ends it.
    assign is_final = rif.i_rlast & (~head.cross4k | (seg_q == SEG_SECOND));
    assign pop      = hs & is_final;
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign push_ok  = cmd_push & (~cmd_full | pop);

    assign ddata_gated  = cmd_empty ? '0 : rif.i_rdata;
    assign rif.o_ddata  = ddata_gated;
    assign rif.o_dlast  = rif.i_rlast & is_final & rif.o_dvalid;
    assign rif.o_dresp  = cmd_empty ? 2'b00 :
                          (is_final ? resp_max(resp_acc_q, rif.i_rresp) : rif.i_rresp);

    assign axi_burst_xdata_ok = pop;
    assign len_err            = len_err_q;
    assign cmd_ovf_err        = ovf_err_q;

    // Command storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= '{cross4k: cmd_cross4k, len: cmd_len};
        end
    end

    // Next-state for FIFO control, segment FSM, beat counting and error flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seg_d      = seg_q;
        beat_cnt_d = beat_cnt_q;
        resp_acc_d = resp_acc_q;
        len_err_d  = len_err_q;
        ovf_err_d  = ovf_err_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        if (cmd_push && cmd_full && !pop) begin
            ovf_err_d = 1'b1;
        end

        if (hs) begin
            if (is_final) begin
                seg_d      = SEG_FIRST;
                beat_cnt_d = '0;
                resp_acc_d = 2'b00;
                if (beat_cnt_q != {1'b0, head.len}) begin
                    len_err_d = 1'b1;
                end
            end else begin
                if (rif.i_rlast) begin
                    seg_d = SEG_SECOND;
                end
                beat_cnt_d = beat_cnt_q + 5'd1;
                resp_acc_d = resp_max(resp_acc_q, rif.i_rresp);
            end
        end
    end

    // State registers; reset discards any partially delivered burst.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seg_q      <= SEG_FIRST;
            beat_cnt_q <= '0;
            resp_acc_q <= 2'b00;
            len_err_q  <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seg_q      <= seg_d;
            beat_cnt_q <= beat_cnt_d;
            resp_acc_q <= resp_acc_d;
            len_err_q  <= len_err_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

endmodule

// File: tb/tb_axi_rdata_merge4k.sv
// Scoreboard bench for axi_rdata_merge4k: the stimulus pushes each expected
// merged beat, a negedge monitor pops and compares every delivered beat.
module tb_axi_rdata_merge4k;

    logic        aclk;
    logic        aresetn;
    logic        cmd_push;
    logic        cmd_cross4k;
    logic [3:0]  cmd_len;
    logic        cmd_full;
    logic        cmd_empty;
    logic        axi_burst_xdata_ok;
    logic        len_err;
    logic        cmd_ovf_err;

    axi_rdata_merge4k_if #(.AXI_IDW(4), .AXI_DW(128)) rif ();

    axi_rdata_merge4k #(.AXI_IDW(4), .AXI_DW(128), .CMD_DEPTH(4)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .cmd_push           (cmd_push),
        .cmd_cross4k        (cmd_cross4k),
        .cmd_len            (cmd_len),
        .cmd_full           (cmd_full),
        .cmd_empty          (cmd_empty),
        .rif                (rif),
        .axi_burst_xdata_ok (axi_burst_xdata_ok),
        .len_err            (len_err),
        .cmd_ovf_err        (cmd_ovf_err)
    );

    typedef struct {
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    ok_cnt   = 0;
    bit    bp_mode  = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every delivered beat against the scoreboard.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (rif.o_dvalid && rif.i_dready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h expected=none", rif.o_ddata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", rif.o_ddata, e.data);
                    chk("beat_resp", 128'(rif.o_dresp), 128'(e.resp));
                    chk("beat_last", 128'(rif.o_dlast), 128'(e.last));
                end
            end
            if (axi_burst_xdata_ok) ok_cnt++;
            if (bp_mode && !cmd_empty) chk("rready_tracks_dready", 128'(rif.o_rready), 128'(rif.i_dready));
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic push_cmd(input logic c4k, input logic [3:0] len);
        cmd_cross4k = c4k;
        cmd_len     = len;
        cmd_push    = 1'b1;
        @(posedge aclk); #1;
        cmd_push    = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [1:0] r, input logic l,
                             input logic [1:0] er, input logic el);
        int n;
        beat_t e;
        e.data = d; e.resp = er; e.last = el;
        exp_q.push_back(e);
        rif.i_rvalid = 1'b1;
        rif.i_rdata  = d;
        rif.i_rresp  = r;
        rif.i_rlast  = l;
        if (bp_mode) rif.i_dready = ~rif.i_dready;
        n = 0;
        forever begin
            @(negedge aclk);
            if (rif.o_rready || n >= 200) break;
            @(posedge aclk); #1;
            if (bp_mode) rif.i_dready = ~rif.i_dready;
            n++;
        end
        if (!rif.o_rready) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout actual=no_rready expected=rready");
            void'(exp_q.pop_back());
        end
        @(posedge aclk); #1;
        rif.i_rvalid = 1'b0;
        rif.i_rlast  = 1'b0;
        rif.i_rresp  = 2'b00;
    endtask

    // n beats; RLAST on beat seg_last (0-based, -1 none) and on the last beat;
    // SLVERR on err_beat. Expected: last only at the end, worst resp on last beat.
    task automatic burst(input int n, input int seg_last, input int err_beat, input logic [7:0] tag);
        logic [1:0]   r;
        logic [1:0]   worst;
        logic [127:0] d;
        int           ok0;
        worst = 2'd0;
        for (int i = 0; i < n; i++) begin
            r = (i == err_beat) ? 2'd2 : 2'd0;
            if (r > worst) worst = r;
            d = (128'(tag) << 64) | 128'h5A00_0000 | 128'(i);
            ok0 = ok_cnt;
            send_beat(d, r, (i == n-1) || (i == seg_last), (i == n-1) ? worst : r, i == n-1);
            if (i == seg_last) begin
                chk("seg_boundary_no_pop", 128'(cmd_empty), 128'(0));
                chk("seg_boundary_no_ok", 128'(ok_cnt), 128'(ok0));
            end
        end
    endtask

    initial begin
        int ok0;
        beat_t e;
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok0;
        beat_t e;
        aresetn      = 1'b0;
        cmd_push     = 1'b0;
        cmd_cross4k  = 1'b0;
        cmd_len      = 4'd0;
        rif.i_rvalid = 1'b1;
        rif.i_rid    = 4'd3;
        rif.i_rdata  = 128'hFFFF_0000_1234;
        rif.i_rresp  = 2'd3;
        rif.i_rlast  = 1'b1;
        rif.i_dready = 1'b1;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;

        // Reset state and empty-FIFO gating with live R inputs.
        chk("rst_cmd_empty", 128'(cmd_empty), 128'(1));
        chk("rst_cmd_full", 128'(cmd_full), 128'(0));
        chk("rst_len_err", 128'(len_err), 128'(0));
        chk("rst_ovf_err", 128'(cmd_ovf_err), 128'(0));
        chk("empty_rready", 128'(rif.o_rready), 128'(0));
        chk("empty_dvalid", 128'(rif.o_dvalid), 128'(0));
        chk("empty_ddata", rif.o_ddata, 128'(0));
        chk("empty_dresp", 128'(rif.o_dresp), 128'(0));
        chk("empty_dlast", 128'(rif.o_dlast), 128'(0));
        chk("empty_xdata_ok", 128'(axi_burst_xdata_ok), 128'(0));
        rif.i_rvalid = 1'b0;
        rif.i_rlast  = 1'b0;
        rif.i_rresp  = 2'd0;

        // Non-split {0,7}; entry not visible in the push cycle.
        ok0 = ok_cnt;
        cmd_cross4k = 1'b0; cmd_len = 4'd7; cmd_push = 1'b1;
        @(negedge aclk);
        chk("push_cycle_rready", 128'(rif.o_rready), 128'(0));
        @(posedge aclk); #1;
        cmd_push = 1'b0;
        @(negedge aclk);
        chk("after_push_rready", 128'(rif.o_rready), 128'(1));
        @(posedge aclk); #1;
        burst(8, -1, -1, 8'h01);
        chk("nonsplit_ok_cnt", 128'(ok_cnt), 128'(ok0 + 1));
        chk("nonsplit_empty", 128'(cmd_empty), 128'(1));
        chk("nonsplit_len_err", 128'(len_err), 128'(0));

        // 4K split {1,7}: RLAST on beats 4 and 8.
        ok0 = ok_cnt;
        push_cmd(1'b1, 4'd7);
        burst(8, 3, -1, 8'h02);
        chk("split_ok_cnt", 128'(ok_cnt), 128'(ok0 + 1));
        chk("split_empty", 128'(cmd_empty), 128'(1));

        // Response merge: SLVERR on beat 2 of a split burst.
        push_cmd(1'b1, 4'd7);
        burst(8, 3, 1, 8'h03);
        chk("resp_len_err", 128'(len_err), 128'(0));

        // Backpressure: i_dready toggles during a split burst.
        ok0 = ok_cnt;
        push_cmd(1'b1, 4'd7);
        bp_mode = 1;
        burst(8, 3, -1, 8'h04);
        bp_mode = 0;
        rif.i_dready = 1'b1;
        chk("bp_ok_cnt", 128'(ok_cnt), 128'(ok0 + 1));
        chk("bp_sb_drained", 128'(exp_q.size()), 128'(0));

        // FIFO full, overflow, push concurrent with final pop at full.
        for (int i = 0; i < 4; i++) push_cmd(1'b0, 4'd0);
        chk("fifo_full", 128'(cmd_full), 128'(1));
        chk("ovf_before", 128'(cmd_ovf_err), 128'(0));
        push_cmd(1'b1, 4'd5);
        chk("ovf_set", 128'(cmd_ovf_err), 128'(1));
        chk("full_after_ovf", 128'(cmd_full), 128'(1));
        ok0 = ok_cnt;
        e.data = 128'hC0C0; e.resp = 2'd1; e.last = 1'b1;
        exp_q.push_back(e);
        rif.i_rvalid = 1'b1; rif.i_rdata = 128'hC0C0; rif.i_rresp = 2'd1; rif.i_rlast = 1'b1;
        cmd_push = 1'b1; cmd_cross4k = 1'b0; cmd_len = 4'd0;
        @(posedge aclk); #1;
        cmd_push = 1'b0; rif.i_rvalid = 1'b0; rif.i_rlast = 1'b0; rif.i_rresp = 2'd0;
        chk("push_pop_full_ok", 128'(ok_cnt), 128'(ok0 + 1));
        chk("push_pop_full_stays", 128'(cmd_full), 128'(1));
        for (int i = 0; i < 3; i++) send_beat(128'hD000 + 128'(i), 2'd0, 1'b1, 2'd0, 1'b1);
        chk("three_left_one", 128'(cmd_empty), 128'(0));
        send_beat(128'hD003, 2'd0, 1'b1, 2'd0, 1'b1);
        chk("four_drained_empty", 128'(cmd_empty), 128'(1));
        chk("drain_ok_cnt", 128'(ok_cnt), 128'(ok0 + 5));
        chk("drain_len_err", 128'(len_err), 128'(0));

        // Length error: {0,7} but RLAST on beat 5.
        push_cmd(1'b0, 4'd7);
        burst(5, -1, -1, 8'h05);
        chk("len_err_set", 128'(len_err), 128'(1));
        chk("len_err_popped", 128'(cmd_empty), 128'(1));

        // Reset mid-burst of a split logical burst.
        push_cmd(1'b1, 4'd7);
        send_beat(128'hE000, 2'd0, 1'b0, 2'd0, 1'b0);
        send_beat(128'hE001, 2'd0, 1'b0, 2'd0, 1'b0);
        rif.i_rvalid = 1'b1; rif.i_rdata = 128'hE002; rif.i_rlast = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_empty", 128'(cmd_empty), 128'(1));
        chk("rst_mid_full", 128'(cmd_full), 128'(0));
        chk("rst_mid_len_err", 128'(len_err), 128'(0));
        chk("rst_mid_ovf_err", 128'(cmd_ovf_err), 128'(0));
        chk("rst_mid_dvalid", 128'(rif.o_dvalid), 128'(0));
        chk("rst_mid_rready", 128'(rif.o_rready), 128'(0));
        chk("rst_mid_dlast", 128'(rif.o_dlast), 128'(0));
        chk("rst_mid_xdata_ok", 128'(axi_burst_xdata_ok), 128'(0));
        rif.i_rvalid = 1'b0; rif.i_rlast = 1'b0;
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("final_sb_empty", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
